status_axil_regbank: RTL and testbench

STATUS_AXIL_REGBANK -- requirements
Module: status_axil_regbank

---
 rtl/status_axil_regbank_pkg.sv | 11 +
 rtl/status_axil_regbank_if.sv | 53 +++++
 rtl/status_axil_regbank_evt_irq.sv | 38 +++
 rtl/status_axil_regbank.sv | 224 ++++++++++++++++++++++
 tb/tb_status_axil_regbank.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/status_axil_regbank_pkg.sv
// Shared definitions for the status/control AXI4-Lite register bank:
// response codes and the write/read channel state enumerations.
package status_axil_regbank_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/status_axil_regbank_if.sv
// AXI4-Lite bus bundle for status_axil_regbank.
// master modport: drives AW/W/AR channels and B/R ready.
// slave modport : drives the ready/response/read-data side.
interface status_axil_regbank_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 8
);
  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                S_AXI_AWPROT;
  logic                      S_AXI_AWVALID;
  logic                      S_AXI_AWREADY;
  logic [C_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                      S_AXI_WVALID;
  logic                      S_AXI_WREADY;
  logic [1:0]                S_AXI_BRESP;
  logic                      S_AXI_BVALID;
  logic                      S_AXI_BREADY;
  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                S_AXI_ARPROT;
  logic                      S_AXI_ARVALID;
  logic                      S_AXI_ARREADY;
  logic [C_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                S_AXI_RRESP;
  logic                      S_AXI_RVALID;
  logic                      S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/status_axil_regbank_evt_irq.sv
// Sticky event register, interrupt enable register and registered irq.
// Ports: clk/rst_n (async active-low), event_in level sources,
// clr_en + wdata/wmask for write-1-to-clear of EVT, en_we for IRQ_EN
// byte-masked writes, evt/irq_en register contents, irq output.
module status_evt_irq #(
  parameter int C_NUM_EVT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [C_NUM_EVT-1:0] event_in,
  input  logic                 clr_en,
  input  logic                 en_we,
  input  logic [C_NUM_EVT-1:0] wdata,
  input  logic [C_NUM_EVT-1:0] wmask,
  output logic [C_NUM_EVT-1:0] evt,
  output logic [C_NUM_EVT-1:0] irq_en,
  output logic                 irq
);
  logic [C_NUM_EVT-1:0] clr_bits;

  always_comb begin
    clr_bits = '0;
    if (clr_en) clr_bits = wdata & wmask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt    <= '0;
      irq_en <= '0;
      irq    <= 1'b0;
    end else begin
      // OR-ing event_in after the clear makes a coincident set win
      evt <= (evt & ~clr_bits) | event_in;
      if (en_we) irq_en <= (irq_en & ~wmask) | (wdata & wmask);
      irq <= |(evt & irq_en);
    end
  end
endmodule

// File: rtl/status_axil_regbank.sv
// AXI4-Lite register bank: C_NUM_CTRL read/write control words, C_NUM_STAT
// read-only status words, a sticky W1C event register and an IRQ enable.
// Ports: ACLK, ARESETN (async active-low), s_axi (AXI4-Lite slave bundle),
// ctrl_out (control words, word 0 in LSBs), stat_in (status words),
// event_in (level event sources), irq (registered interrupt).
module status_axil_regbank
  import status_axil_regbank_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 8,
  parameter int C_NUM_CTRL   = 4,
  parameter int C_NUM_STAT   = 4,
  parameter int C_NUM_EVT    = 8
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  status_axil_regbank_if.slave               s_axi,
  output logic [C_NUM_CTRL*C_DATA_WIDTH-1:0] ctrl_out,
  input  logic [C_NUM_STAT*C_DATA_WIDTH-1:0] stat_in,
  input  logic [C_NUM_EVT-1:0]               event_in,
  output logic                               irq
);
  localparam int unsigned NBYTES   = C_DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(NBYTES);
  localparam int unsigned IDX_W    = C_ADDR_WIDTH - ADDR_LSB;
  localparam logic [IDX_W-1:0] EVT_IDX   = IDX_W'(C_NUM_CTRL + C_NUM_STAT);
  localparam logic [IDX_W-1:0] IRQEN_IDX = IDX_W'(C_NUM_CTRL + C_NUM_STAT + 1);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                    ready_en;
  logic                    aw_held, w_held;
  logic [IDX_W-1:0]        aw_idx_q;
  logic [C_DATA_WIDTH-1:0] wdata_q, wmask;
  logic [NBYTES-1:0]       wstrb_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [C_DATA_WIDTH-1:0] rdata_q, rd_val;
  logic                    rd_err, wr_err, evt_sel, irqen_sel;
  logic [C_NUM_CTRL-1:0]   ctrl_sel;
  logic [C_DATA_WIDTH-1:0] ctrl_q [C_NUM_CTRL];
  logic [C_DATA_WIDTH-1:0] stat_q [C_NUM_STAT];
  logic [C_NUM_EVT-1:0]    evt, irq_en;
  logic [IDX_W-1:0]        ar_idx;
  logic                    aw_hs, w_hs, ar_hs, commit;
  logic                    unused_bits;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[ADDR_LSB-1:0],
                         s_axi.S_AXI_ARADDR[ADDR_LSB-1:0]};

  // ready_en keeps all READYs low through reset and the first edge after it
  assign s_axi.S_AXI_AWREADY = ready_en & ~aw_held;
  assign s_axi.S_AXI_WREADY  = ready_en & ~w_held;
  assign s_axi.S_AXI_ARREADY = ready_en & (rd_state == R_IDLE);
  assign s_axi.S_AXI_BVALID  = (wr_state == W_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = (rd_state == R_DATA);
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;

  assign aw_hs  = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
  assign w_hs   = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
  assign ar_hs  = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
  assign commit = (wr_state == W_IDLE) & aw_held & w_held;
  assign ar_idx = s_axi.S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_held && w_held) wr_next = W_RESP;
      W_RESP:  if (s_axi.S_AXI_BREADY) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (s_axi.S_AXI_RREADY) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      ready_en <= 1'b1;
      if (wr_state == W_RESP && s_axi.S_AXI_BREADY) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_axi.S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= s_axi.S_AXI_WDATA;
          wstrb_q <= s_axi.S_AXI_WSTRB;
        end
      end
    end
  end

  always_comb begin
    wmask = '0;
    for (int unsigned b = 0; b < NBYTES; b++) wmask[b*8 +: 8] = {8{wstrb_q[b]}};
  end

  // STAT indices and anything past IRQ_EN leave wr_err set
  always_comb begin
    wr_err    = 1'b1;
    ctrl_sel  = '0;
    evt_sel   = 1'b0;
    irqen_sel = 1'b0;
    for (int unsigned i = 0; i < C_NUM_CTRL; i++) begin
      if (aw_idx_q == IDX_W'(i)) begin
        ctrl_sel[i] = 1'b1;
        wr_err      = 1'b0;
      end
    end
    if (aw_idx_q == EVT_IDX) begin
      evt_sel = 1'b1;
      wr_err  = 1'b0;
    end
    if (aw_idx_q == IRQEN_IDX) begin
      irqen_sel = 1'b1;
      wr_err    = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bresp_q <= RESP_OKAY;
      for (int unsigned i = 0; i < C_NUM_CTRL; i++) ctrl_q[i] <= '0;
    end else if (commit) begin
      bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      for (int unsigned i = 0; i < C_NUM_CTRL; i++) begin
        if (ctrl_sel[i]) ctrl_q[i] <= (ctrl_q[i] & ~wmask) | (wdata_q & wmask);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned j = 0; j < C_NUM_STAT; j++) stat_q[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < C_NUM_STAT; j++) stat_q[j] <= stat_in[j*C_DATA_WIDTH +: C_DATA_WIDTH];
    end
  end

  always_comb begin
    ctrl_out = '0;
    for (int unsigned i = 0; i < C_NUM_CTRL; i++) ctrl_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = ctrl_q[i];
  end

  always_comb begin
    rd_val = '0;
    rd_err = 1'b1;
    for (int unsigned i = 0; i < C_NUM_CTRL; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_val = ctrl_q[i];
        rd_err = 1'b0;
      end
    end
    for (int unsigned j = 0; j < C_NUM_STAT; j++) begin
      if (ar_idx == IDX_W'(C_NUM_CTRL + j)) begin
        rd_val = stat_q[j];
        rd_err = 1'b0;
      end
    end
    if (ar_idx == EVT_IDX) begin
      rd_val = C_DATA_WIDTH'(evt);
      rd_err = 1'b0;
    end
    if (ar_idx == IRQEN_IDX) begin
      rd_val = C_DATA_WIDTH'(irq_en);
      rd_err = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_val;
      rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end
  end

  status_evt_irq #(
    .C_NUM_EVT (C_NUM_EVT)
  ) u_evt_irq (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .event_in (event_in),
    .clr_en   (commit & evt_sel),
    .en_we    (commit & irqen_sel),
    .wdata    (wdata_q[C_NUM_EVT-1:0]),
    .wmask    (wmask[C_NUM_EVT-1:0]),
    .evt      (evt),
    .irq_en   (irq_en),
    .irq      (irq)
  );
endmodule

// File: tb/tb_status_axil_regbank.sv
module tb_status_axil_regbank;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] ctrl_out;
  logic [127:0] stat_in;
  logic [7:0]   event_in;
  logic         irq;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ctrl_m [4];
  logic [31:0] stat_m [4];
  logic [7:0]  evt_m, irqen_m;

  status_axil_regbank_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(8)) bus ();

  status_axil_regbank dut (
    .ACLK     (clk),
    .ARESETN  (rst_n),
    .s_axi    (bus),
    .ctrl_out (ctrl_out),
    .stat_in  (stat_in),
    .event_in (event_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{strb[b]}};
    return m;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) ctrl_m[i] = '0;
    evt_m   = '0;
    irqen_m = '0;
  endfunction

  // Register-map model: index = byte address / 4
  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] strb);
    int idx;
    logic [31:0] m;
    idx = int'(addr) / 4;
    m = strb_mask(strb);
    if (idx < 4) ctrl_m[idx] = (ctrl_m[idx] & ~m) | (d & m);
    else if (idx < 8) return 2'b10;
    else if (idx == 8) evt_m = evt_m & ~(d[7:0] & m[7:0]);
    else if (idx == 9) irqen_m = (irqen_m & ~m[7:0]) | (d[7:0] & m[7:0]);
    else return 2'b10;
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] r);
    int idx;
    idx = int'(addr) / 4;
    r = 2'b00;
    d = '0;
    if (idx < 4) d = ctrl_m[idx];
    else if (idx < 8) d = stat_m[idx-4];
    else if (idx == 8) d = {24'h0, evt_m};
    else if (idx == 9) d = {24'h0, irqen_m};
    else r = 2'b10;
  endfunction

  // AWVALID rises aw_at cycles and WVALID w_at cycles after the call
  task automatic axi_write(input logic [7:0] addr, input logic [31:0] d, input logic [3:0] strb,
                           input int aw_at, input int w_at, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int c = 0;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = strb;
    bus.S_AXI_AWVALID = (aw_at == 0);
    bus.S_AXI_WVALID  = (w_at == 0);
    bus.S_AXI_BREADY = 1'b1;
    while (!(aw_done && w_done) && c < 50) begin
      aw_fire = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_fire  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      c++;
      if (aw_fire) begin aw_done = 1; bus.S_AXI_AWVALID = 0; end
      if (w_fire)  begin w_done = 1;  bus.S_AXI_WVALID = 0;  end
      if (!aw_done && c >= aw_at) bus.S_AXI_AWVALID = 1;
      if (!w_done && c >= w_at) bus.S_AXI_WVALID = 1;
    end
    bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WVALID  = 0;
    check("aw_w_accept", {aw_done, w_done}, 2'b11);
    c = 0;
    while (!bus.S_AXI_BVALID && c < 20) begin tick(); c++; end
    check("bvalid_seen", bus.S_AXI_BVALID, 1'b1);
    resp = bus.S_AXI_BRESP;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    check("bvalid_single", bus.S_AXI_BVALID, 1'b0);
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] resp);
    bit done = 0, fire;
    int c = 0;
    bus.S_AXI_ARADDR  = addr;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b1;
    while (!done && c < 50) begin
      fire = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      tick();
      c++;
      if (fire) begin done = 1; bus.S_AXI_ARVALID = 0; end
    end
    bus.S_AXI_ARVALID = 0;
    check("ar_accept", done, 1'b1);
    check("rvalid_lat1", bus.S_AXI_RVALID, 1'b1);
    d = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    check("rvalid_drop", bus.S_AXI_RVALID, 1'b0);
  endtask

  task automatic wr_chk(input string tag, input logic [7:0] addr, input logic [31:0] d, input logic [3:0] strb,
                        input int aw_at, input int w_at);
    logic [1:0] resp, er;
    axi_write(addr, d, strb, aw_at, w_at, resp);
    er = model_write(addr, d, strb);
    check(tag, resp, er);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] addr);
    logic [31:0] d, ed;
    logic [1:0]  r, er;
    axi_read(addr, d, r);
    model_read(addr, ed, er);
    check(tag, d, ed);
    check(tag, r, er);
  endtask

  task automatic check_outputs_zero(input string tag);
    check(tag, {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY, bus.S_AXI_BVALID,
                bus.S_AXI_RVALID, irq, bus.S_AXI_BRESP, bus.S_AXI_RRESP}, '0);
    check(tag, {bus.S_AXI_RDATA, ctrl_out[31:0]}, '0);
    check(tag, ctrl_out[127:64], '0);
  endtask

  initial begin
    logic [31:0] d, snap;
    logic [1:0]  r;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = '0;  bus.S_AXI_WSTRB = '0;  bus.S_AXI_WVALID = 0;
    bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY = 0;
    stat_in = '0; event_in = '0;
    for (int i = 0; i < 4; i++) stat_m[i] = '0;
    model_reset();

    // reset state, readies rise on first edge after release
    rst_n = 0;
    #23;
    check_outputs_zero("reset_outputs");
    rst_n = 1;
    #1;
    check("ready_before_edge", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
    tick();
    check("ready_after_edge", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b111);

    // control registers full-word write and readback
    wr_chk("ctrl_bresp", 8'h00, 32'h0101FFFF, 4'hF, 0, 0);
    wr_chk("ctrl_bresp", 8'h04, 32'hABCD0001, 4'hF, 0, 0);
    wr_chk("ctrl_bresp", 8'h08, 32'hDEAD0011, 4'hF, 1, 0);
    wr_chk("ctrl_bresp", 8'h0C, 32'hBEEF0011, 4'hF, 0, 1);
    for (int i = 0; i < 4; i++) rd_chk("ctrl_read", 8'(i * 4));
    check("ctrl_out", ctrl_out, {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]});
    check("ctrl_out_const", ctrl_out, {32'hBEEF0011, 32'hDEAD0011, 32'hABCD0001, 32'h0101FFFF});

    // byte strobes, then W two cycles ahead of AW
    wr_chk("strb_clear", 8'h00, 32'h0, 4'hF, 0, 0);
    wr_chk("strb_bresp", 8'h00, 32'h12345678, 4'b0101, 0, 0);
    axi_read(8'h00, d, r);
    check("strb_read", d, 32'h00340078);
    wr_chk("w_first_bresp", 8'h04, 32'h5A5AA5A5, 4'hF, 2, 0);
    rd_chk("w_first_read", 8'h04);

    // status sampling and error responses
    stat_in[95:64] = 32'hCAFEF00D; stat_m[2] = 32'hCAFEF00D;
    tick(); tick();
    axi_read(8'h18, d, r);
    check("stat_read", d, 32'hCAFEF00D);
    check("stat_resp", r, 2'b00);
    wr_chk("stat_wr_slverr", 8'h18, 32'h11111111, 4'hF, 0, 0);
    rd_chk("stat_unchanged", 8'h18);
    axi_read(8'h28, d, r);
    check("oob_rdata", d, 32'h0);
    check("oob_rresp", r, 2'b10);

    // sticky event, irq, W1C, set-wins-over-clear
    wr_chk("irqen_wr", 8'h24, 32'h00000008, 4'hF, 0, 0);
    event_in[3] = 1'b1; tick(); event_in[3] = 1'b0;
    evt_m = 8'h08;
    tick(); tick();
    axi_read(8'h20, d, r);
    check("evt_set", d, 32'h08);
    check("irq_set", irq, 1'b1);
    wr_chk("evt_clr", 8'h20, 32'h08, 4'hF, 0, 0);
    tick();
    rd_chk("evt_cleared", 8'h20);
    check("irq_clr", irq, 1'b0);
    event_in[3] = 1'b1;
    evt_m = 8'h08;
    wr_chk("evt_clr_hold", 8'h20, 32'h08, 4'hF, 0, 0);
    evt_m = 8'h08;
    rd_chk("evt_set_wins", 8'h20);
    event_in[3] = 1'b0;
    wr_chk("evt_clr2", 8'h20, 32'hFF, 4'hF, 0, 0);
    rd_chk("evt_zero", 8'h20);

    // backpressure; read hits the same register on its write-commit edge
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_WDATA = 32'h600DF00D; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1; bus.S_AXI_WVALID = 1;
    tick();
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_ARADDR = 8'h00; bus.S_AXI_ARVALID = 1;
    tick();
    bus.S_AXI_ARVALID = 0;
    check("stall_pre_write_read", bus.S_AXI_RDATA, ctrl_m[0]);
    snap = bus.S_AXI_RDATA;
    void'(model_write(8'h00, 32'h600DF00D, 4'hF));
    bus.S_AXI_AWADDR = 8'h04; bus.S_AXI_AWVALID = 1;
    bus.S_AXI_ARADDR = 8'h04; bus.S_AXI_ARVALID = 1;
    for (int k = 0; k < 5; k++) begin
      check("stall_valids", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b11);
      check("stall_data", {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_BRESP}, {snap, 4'b0000});
      check("stall_readies", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_ARREADY}, 3'b000);
      tick();
    end
    bus.S_AXI_AWVALID = 0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_BREADY = 1; bus.S_AXI_RREADY = 1;
    tick();
    bus.S_AXI_BREADY = 0; bus.S_AXI_RREADY = 0;
    check("stall_release", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    rd_chk("stall_committed", 8'h00);
    rd_chk("stall_no_extra_write", 8'h04);

    // randomized traffic against the model
    for (int i = 0; i < 4; i++) begin
      stat_m[i] = $urandom;
      stat_in[i*32 +: 32] = stat_m[i];
    end
    tick(); tick();
    for (int k = 0; k < 150; k++) begin
      logic [7:0] addr;
      addr = 8'(($urandom_range(0, 11) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wr_chk("rnd_bresp", addr, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        tick();
        check("rnd_irq", irq, |(evt_m & irqen_m));
      end else begin
        rd_chk("rnd_read", addr);
      end
    end
    check("rnd_ctrl_out", ctrl_out, {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]});

    // reset between AW and W beats
    bus.S_AXI_AWADDR = 8'h00; bus.S_AXI_AWVALID = 1;
    tick();
    bus.S_AXI_AWVALID = 0;
    #2 rst_n = 0;
    #1;
    check_outputs_zero("mid_reset_outputs");
    model_reset();
    tick(); tick();
    rst_n = 1;
    tick();
    axi_read(8'h00, d, r);
    check("post_reset_read", d, 32'h0);
    check("post_reset_resp", r, 2'b00);
    wr_chk("post_reset_wr", 8'h0C, 32'h00C0FFEE, 4'hF, 0, 0);
    rd_chk("post_reset_rd", 8'h0C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
